alu_exec: RTL and testbench

Execute-stage ALU consuming the 4-bit `alucontrol` code from the ALU control decoder plus two operands. It produces a registered result, zero flag and illegal-op flag behind valid/ready handshakes on both sides. Logic and arithmetic ops complete in one cycle. Shift ops run iteratively, one bit per cycle, so the block back-pressures the decode stage while a shift is in flight.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_shift_step.sv | 22 ++
 rtl/alu_exec.sv | 167 ++++++++++++++++
 tb/tb_alu_exec.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: alucontrol code values (also used by the ALU control
// decoder) and the execute-stage FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_JALR = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-bit shift of a WIDTH-bit word for SLL/SRL/SRA;
// any other code passes the word through unchanged.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        case (op)
            ALU_SLL: q = {d[WIDTH-2:0], 1'b0};
            ALU_SRL: q = {1'b0, d[WIDTH-1:1]};
            ALU_SRA: q = {d[WIDTH-1], d[WIDTH-1:1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready on both sides. Define ALU_EXEC_SHIFT_EN to
// build the iterative (one bit per cycle) shifter; otherwise shift codes are illegal.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic             accept;
    logic             start_shift;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] op_result;
    logic             op_illegal;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    assign accept = in_valid & in_ready;
    assign sum    = a + b;

`ifdef ALU_EXEC_SHIFT_EN
    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    logic [SHW-1:0]   shamt;
    logic [SHW-1:0]   cnt;
    logic [3:0]       shift_op;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_step;
    logic             shift_last;

    assign shamt      = b[SHW-1:0];
    assign shift_last = (state == ST_SHIFT) && (cnt == CNT_ONE);

    alu_shift_step #(.WIDTH(WIDTH)) u_shift_step (
        .op (shift_op),
        .d  (work),
        .q  (work_step)
    );
`endif

    // Single-cycle result for the code on the inputs; shifts by zero complete here too.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        op_result   = '0;
        op_illegal  = 1'b0;
        start_shift = 1'b0;
        case (alucontrol)
            ALU_AND:  op_result = a & b;
            ALU_OR:   op_result = a | b;
            ALU_ADD:  op_result = sum;
            ALU_SUB:  op_result = a - b;
            ALU_SLT:  op_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_JALR: op_result = {sum[WIDTH-1:1], 1'b0};
            ALU_SLL, ALU_SRL, ALU_SRA: begin
`ifdef ALU_EXEC_SHIFT_EN
                if (shamt == '0) begin
                    op_result = a;
                end else begin
                    start_shift = 1'b1;
                end
`else
                op_illegal = 1'b1;
`endif
            end
            default:  op_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = start_shift ? ST_SHIFT : ST_HOLD;
                end
            end
`ifdef ALU_EXEC_SHIFT_EN
            ST_SHIFT: begin
                if (shift_last) begin
                    state_nxt = ST_HOLD;
                end
            end
`endif
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_nxt = start_shift ? ST_SHIFT : ST_HOLD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result, zero and illegal load together and only when a result completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else if (accept && !start_shift) begin
            result_q  <= op_result;
            zero_q    <= (op_result == '0);
            illegal_q <= op_illegal;
`ifdef ALU_EXEC_SHIFT_EN
        end else if (shift_last) begin
            result_q  <= work_step;
            zero_q    <= (work_step == '0);
            illegal_q <= 1'b0;
`endif
        end
    end

`ifdef ALU_EXEC_SHIFT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work     <= '0;
            cnt      <= '0;
            shift_op <= ALU_SLL;
        end else if (accept && start_shift) begin
            work     <= a;
            cnt      <= shamt;
            shift_op <= alucontrol;
        end else if (state == ST_SHIFT) begin
            work     <= work_step;
            cnt      <= cnt - CNT_ONE;
        end
    end
`endif

    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec; shift scenarios are built only
// when ALU_EXEC_SHIFT_EN is defined, otherwise shift codes are checked as illegal.
module tb_alu_exec;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   alucontrol = 4'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    alu_exec #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] code, input logic [W-1:0] x, input logic [W-1:0] y);
        alucontrol = code;
        a          = x;
        b          = y;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

`ifdef ALU_EXEC_SHIFT_EN
    task automatic run_shift(input string tag, input logic [3:0] code, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic [W-1:0] exp_res, input int exp_lat);
        int lat;
        int stalls;
        issue(code, x, y);
        lat    = 1;
        stalls = 0;
        while (!out_valid && lat < 200) begin
            if (!in_ready) stalls++;
            tick();
            lat++;
        end
        check({tag, " latency"}, W'(lat), W'(exp_lat));
        check({tag, " stall cycles"}, W'(stalls), W'(exp_lat - 1));
        check({tag, " result"}, result, exp_res);
        check({tag, " illegal"}, illegal, 1'b0);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        tick();
        tick();
        check("reset out_valid", out_valid, 1'b0);
        check("reset result", result, '0);
        check("reset zero", zero, 1'b1);
        check("reset illegal", illegal, 1'b0);
        reset = 1'b0;
        tick();
        check("idle in_ready", in_ready, 1'b1);

        // ADD wraps to zero, one-cycle latency; held with out_ready low
        out_ready = 1'b0;
        issue(ALU_ADD, 32'hFFFF_FFFF, 32'h1);
        check("add out_valid", out_valid, 1'b1);
        check("add result", result, 32'h0);
        check("add zero", zero, 1'b1);

        // Back-pressure for 5 cycles while inputs churn
        in_valid   = 1'b1;
        alucontrol = ALU_OR;
        for (int i = 0; i < 5; i++) begin
            a = 32'h1111_0000 + W'(i);
            b = 32'h0000_2222;
            check("bp in_ready", in_ready, 1'b0);
            tick();
            check("bp result", result, 32'h0);
            check("bp out_valid", out_valid, 1'b1);
        end

        // Release with a new op present: accepted in the same cycle
        out_ready  = 1'b1;
        alucontrol = ALU_SUB;
        a          = 32'd5;
        b          = 32'd7;
        #1;
        check("release in_ready", in_ready, 1'b1);
        tick();
        check("sub result", result, 32'hFFFF_FFFE);
        check("sub zero", zero, 1'b0);
        check("sub out_valid", out_valid, 1'b1);

        // Back-to-back one-cycle ops
        alucontrol = ALU_SLT; a = 32'h8000_0000; b = 32'h1;
        tick();
        check("slt neg<pos", result, 32'h1);
        alucontrol = ALU_SLT; a = 32'h1; b = 32'h8000_0000;
        tick();
        check("slt pos<neg", result, 32'h0);
        check("slt zero", zero, 1'b1);
        alucontrol = ALU_JALR; a = 32'h1003; b = 32'h4;
        tick();
        check("jalr result", result, 32'h1006);
        alucontrol = 4'b1111; a = 32'hDEAD_BEEF; b = 32'h1234;
        tick();
        check("illegal result", result, 32'h0);
        check("illegal flag", illegal, 1'b1);
        check("illegal out_valid", out_valid, 1'b1);
        alucontrol = ALU_OR; a = 32'h0000_00F0; b = 32'h0000_000F;
        tick();
        check("or result", result, 32'h0000_00FF);
        check("or illegal clear", illegal, 1'b0);
        alucontrol = ALU_AND; a = 32'h0000_F0F0; b = 32'h0000_FF00;
        tick();
        check("and result", result, 32'h0000_F000);
        alucontrol = ALU_ADD; a = 32'h7FFF_FFFF; b = 32'h2;
        tick();
        check("add carry", result, 32'h8000_0001);

        // Drain to IDLE
        in_valid = 1'b0;
        tick();
        check("drain out_valid", out_valid, 1'b0);
        check("drain in_ready", in_ready, 1'b1);

`ifdef ALU_EXEC_SHIFT_EN
        run_shift("sra31", ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32);
        check("sra31 zero", zero, 1'b0);
        run_shift("sll4", ALU_SLL, 32'h0000_0001, 32'd4, 32'h0000_0010, 5);
        run_shift("srl1", ALU_SRL, 32'h8000_0000, 32'd1, 32'h4000_0000, 2);
        run_shift("sra_pos", ALU_SRA, 32'h4000_0000, 32'd30, 32'h0000_0001, 31);
        run_shift("srl_amt0", ALU_SRL, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1);
        tick();

        // Reset on cycle 3 of a 20-bit SLL aborts immediately
        issue(ALU_SLL, 32'h0000_0001, 32'd20);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst shift out_valid", out_valid, 1'b0);
        check("rst shift result", result, 32'h0);
        check("rst shift zero", zero, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        check("rst shift in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
`else
        issue(ALU_SLL, 32'h0000_0001, 32'd4);
        check("sll disabled out_valid", out_valid, 1'b1);
        check("sll disabled illegal", illegal, 1'b1);
        check("sll disabled result", result, 32'h0);
        issue(ALU_SRA, 32'h8000_0000, 32'd0);
        check("sra disabled illegal", illegal, 1'b1);
        tick();
`endif

        // Reset while holding a result discards it
        out_ready = 1'b0;
        issue(ALU_AND, 32'h0000_FFFF, 32'h0000_00FF);
        check("pre-rst hold result", result, 32'h0000_00FF);
        reset = 1'b1;
        #1;
        check("rst hold out_valid", out_valid, 1'b0);
        check("rst hold result", result, 32'h0);
        check("rst hold zero", zero, 1'b1);
        check("rst hold illegal", illegal, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check("post-rst in_ready", in_ready, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
